// File: rtl/stream_frame_collector.sv
// Packs BEATS consecutive DATA_W-bit samples into one wide frame; io_flush closes a partial frame.
// Define STREAM_FRAME_COLLECTOR_THROTTLE_EN to add LFSR-driven pseudo-random input backpressure.
module stream_frame_collector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned CNT_W  = $clog2(BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    io_in_ready,
  input  logic                    io_in_valid,
  input  logic [DATA_W-1:0]       io_in_bits,
  input  logic                    io_flush,
  input  logic                    io_out_ready,
  output logic                    io_out_valid,
  output logic [DATA_W*BEATS-1:0] io_out_bits,
  output logic [CNT_W-1:0]        io_out_count,
  output logic [15:0]             io_frame_count
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_W*BEATS-1:0] lanes_q, lanes_d;
  logic [15:0]             frames_q, frames_d;
  logic                    throttle_ok;
  logic                    in_fire;
  logic                    out_fire;

`ifdef STREAM_FRAME_COLLECTOR_THROTTLE_EN
  // x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign throttle_ok = lfsr_q[0];
`else
  assign throttle_ok = 1'b1;
`endif

  assign in_fire  = io_in_valid & io_in_ready;
  assign out_fire = io_out_valid & io_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      beat_cnt_q <= '0;
      count_q    <= '0;
      lanes_q    <= '0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      count_q    <= count_d;
      lanes_q    <= lanes_d;
      frames_q   <= frames_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    count_d    = count_q;
    lanes_d    = lanes_q;
    frames_d   = frames_q;
    case (state_q)
      StFill: begin
        if (in_fire) begin
          lanes_d[DATA_W * 32'(beat_cnt_q) +: DATA_W] = io_in_bits;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        // A beat arriving with the flush is included in the closed frame.
        if ((in_fire && (beat_cnt_q == CNT_W'(BEATS - 1))) ||
            (io_flush && (in_fire || (beat_cnt_q != '0)))) begin
          state_d    = StHold;
          count_d    = in_fire ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
          beat_cnt_d = '0;
        end
      end
      StHold: begin
        if (out_fire) begin
          state_d    = StFill;
          frames_d   = frames_q + 16'd1;
          count_d    = '0;
          lanes_d    = '0;
          beat_cnt_d = '0;
          if (in_fire) begin
            lanes_d[DATA_W-1:0] = io_in_bits;
            beat_cnt_d          = CNT_W'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    io_out_valid   = (state_q == StHold);
    io_in_ready    = ((state_q == StFill) | io_out_ready) & throttle_ok;
    io_out_bits    = lanes_q;
    io_out_count   = count_q;
    io_frame_count = frames_q;
  end

endmodule

// File: tb/tb_stream_frame_collector.sv
// Randomized bench for stream_frame_collector against a queue-based frame model,
// preceded by directed frame, flush, backpressure and reset cases.
module tb_stream_frame_collector;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned CNT_W  = 3;

  logic                    clk;
  logic                    reset;
  logic                    io_in_ready;
  logic                    io_in_valid;
  logic [DATA_W-1:0]       io_in_bits;
  logic                    io_flush;
  logic                    io_out_ready;
  logic                    io_out_valid;
  logic [DATA_W*BEATS-1:0] io_out_bits;
  logic [CNT_W-1:0]        io_out_count;
  logic [15:0]             io_frame_count;

  stream_frame_collector #(
    .DATA_W(DATA_W),
    .BEATS (BEATS),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_in_ready   (io_in_ready),
    .io_in_valid   (io_in_valid),
    .io_in_bits    (io_in_bits),
    .io_flush      (io_flush),
    .io_out_ready  (io_out_ready),
    .io_out_valid  (io_out_valid),
    .io_out_bits   (io_out_bits),
    .io_out_count  (io_out_count),
    .io_frame_count(io_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted samples queue up until a frame is closed.
  logic [DATA_W-1:0]       m_part[$];
  logic                    m_hold;
  logic [DATA_W*BEATS-1:0] m_bits;
  logic [CNT_W-1:0]        m_cnt;
  logic [15:0]             m_frames;
  logic [7:0]              m_lfsr;
  logic                    m_acc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_part.delete();
    m_hold   = 1'b0;
    m_bits   = '0;
    m_cnt    = '0;
    m_frames = '0;
    m_lfsr   = 8'hA5;
    m_acc    = 1'b0;
  endtask

  task automatic tick(input logic v, input logic [31:0] d, input logic f, input logic r);
    logic rdy;
    logic was_hold;
    io_in_valid  = v;
    io_in_bits   = d;
    io_flush     = f;
    io_out_ready = r;
    #1;
    rdy = !m_hold || r;
`ifdef STREAM_FRAME_COLLECTOR_THROTTLE_EN
    rdy = rdy && m_lfsr[0];
`endif
    check_eq("in_ready", io_in_ready, rdy);
    check_eq("out_valid", io_out_valid, m_hold);
    if (m_hold) begin
      check_eq("out_bits", io_out_bits, m_bits);
      check_eq("out_count", io_out_count, m_cnt);
    end
    check_eq("frame_count", io_frame_count, m_frames);
    if (reset) begin
      m_reset();
    end else begin
      was_hold = m_hold;
      m_acc    = v && rdy;
      if (m_hold && r) begin
        m_hold   = 1'b0;
        m_frames = m_frames + 16'd1;
      end
      if (m_acc) m_part.push_back(d);
      if (!was_hold && (m_part.size() == BEATS || (f && m_part.size() > 0))) begin
        m_bits = '0;
        foreach (m_part[k]) m_bits[k*DATA_W +: DATA_W] = m_part[k];
        m_cnt = CNT_W'(m_part.size());
        m_part.delete();
        m_hold = 1'b1;
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic r);
    int n = 0;
    m_acc = 1'b0;
    while (!m_acc && n < 50) begin
      tick(1'b1, d, 1'b0, r);
      n++;
    end
    check_eq("send_accepted", m_acc, 1'b1);
  endtask

  task automatic drain();
    repeat (3) tick(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_flush     = 1'b0;
    io_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    check_eq("rst_valid", io_out_valid, 1'b0);
    check_eq("rst_bits", io_out_bits, 128'h0);
    check_eq("rst_count", io_out_count, 3'd0);
    check_eq("rst_frames", io_frame_count, 16'd0);

    // Basic frame 1..4.
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b1);
    check_eq("t1_valid", io_out_valid, 1'b1);
    check_eq("t1_bits", io_out_bits, 128'h00000004_00000003_00000002_00000001);
    check_eq("t1_count", io_out_count, 3'd4);
    check_eq("t1_frames0", io_frame_count, 16'd0);
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("t1_frames1", io_frame_count, 16'd1);

    // Continuous 0x10..0x17.
    for (int i = 0; i < 8; i++) send(32'h10 + 32'(i), 1'b1);
    check_eq("t2_bits", io_out_bits, 128'h00000017_00000016_00000015_00000014);
    drain();

    // Flush of a two-beat partial frame, then flush on an empty collector.
    send(32'hA, 1'b1);
    send(32'hB, 1'b1);
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("t3_bits", io_out_bits, 128'h00000000_00000000_0000000B_0000000A);
    check_eq("t3_count", io_out_count, 3'd2);
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b0, 32'd0, 1'b1, 1'b1);
    check_eq("t3_empty_flush", io_out_valid, 1'b0);
    drain();

    // Backpressure with a held frame.
    for (int i = 0; i < 4; i++) send(32'h40 + 32'(i), 1'b0);
    repeat (10) tick(1'b1, 32'h99, 1'b0, 1'b0);
    check_eq("t4_stable", io_out_bits, 128'h00000043_00000042_00000041_00000040);
`ifndef STREAM_FRAME_COLLECTOR_THROTTLE_EN
    tick(1'b1, 32'h55, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(32'h56 + 32'(i), 1'b0);
    check_eq("t4_lane0", io_out_bits, 128'h00000058_00000057_00000056_00000055);
`endif
    drain();

    // Reset mid-frame.
    send(32'h21, 1'b1);
    send(32'h22, 1'b1);
    reset = 1'b1;
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    check_eq("t5_valid", io_out_valid, 1'b0);
    check_eq("t5_frames", io_frame_count, 16'd0);
    for (int i = 0; i < 4; i++) send(32'h31 + 32'(i), 1'b0);
    check_eq("t5_bits", io_out_bits, 128'h00000034_00000033_00000032_00000031);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(3) != 0, $urandom, $urandom_range(19) == 0, $urandom_range(4) < 3);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
